// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the clear-sequencer state encoding so the top and sub-module agree.
// No logic; types only.
package regfile_mp_pkg;

  // Clear sequencer states: IDLE serves reads/writes, CLEAR sweeps the array to zero.
  typedef enum logic {
    RF_S_IDLE  = 1'b0,
    RF_S_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_clear_seq.sv
// Clear sequencer: walks clr_idx over every register and drives a zero write each cycle.
// Latency: a sweep takes exactly 2**AW cycles; Busy_o drops the cycle after the last clear.
// Clr_i restarts the sweep at index 0; reset forces a fresh sweep asynchronously.
module rf_clear_seq
  import regfile_mp_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          Clk_i,
  input  logic          Rst_ni,
  input  logic          Clr_i,
  output logic          Busy_o,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  rf_state_e     state_q;
  rf_state_e     state_d;
  logic [AW-1:0] idx_d;

  // State and sweep index register; reset lands in CLEAR so the array is scrubbed first.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q <= RF_S_CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      clr_idx <= idx_d;
    end
  end

  // Next-state, next-index and outputs; a clear request always restarts at index 0.
  always_comb begin
    state_d = state_q;
    idx_d   = clr_idx;
    Busy_o  = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      RF_S_IDLE: begin
        if (Clr_i) begin
          state_d = RF_S_CLEAR;
          idx_d   = '0;
        end
      end
      RF_S_CLEAR: begin
        Busy_o = 1'b1;
        clr_we = 1'b1;
        if (Clr_i) begin
          idx_d = '0;
        end else if (clr_idx == {AW{1'b1}}) begin
          state_d = RF_S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = clr_idx + 1'b1;
        end
      end
      default: begin
        state_d = RF_S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RPORTS async read ports, 2 sync write ports (port 1 wins).
// Reads are zero-latency with optional same-cycle write bypass; writes land on the next edge.
// While the clear sweep runs, writes are dropped and every read port returns zero.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RPORTS     = 2,
  parameter int R0_IS_ZERO     = 1,
  parameter int BYPASS         = 1
) (
  input  logic                            Clk_i,
  input  logic                            Rst_ni,
  input  logic                            Clr_i,
  output logic                            Busy_o,
  input  logic [NUM_RPORTS*REG_ADDR_WIDTH-1:0] Rsel_i,
  output logic [NUM_RPORTS*REG_WIDTH-1:0] Rdata_o,
  input  logic                            We0_i,
  input  logic [REG_ADDR_WIDTH-1:0]       Wsel0_i,
  input  logic [REG_WIDTH-1:0]            Wdata0_i,
  input  logic                            We1_i,
  input  logic [REG_ADDR_WIDTH-1:0]       Wsel1_i,
  input  logic [REG_WIDTH-1:0]            Wdata1_i
);

  localparam int AW        = REG_ADDR_WIDTH;
  localparam int REG_COUNT = 2 ** AW;

  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic                 clr_we;
  logic [AW-1:0]        clr_idx;
  logic                 wr0_ok;
  logic                 wr1_ok;

  rf_clear_seq #(
    .AW (AW)
  ) u_clear_seq (
    .Clk_i   (Clk_i),
    .Rst_ni  (Rst_ni),
    .Clr_i   (Clr_i),
    .Busy_o  (Busy_o),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  // Write qualification: nothing lands while clearing, and R0 stays zero when hardwired.
  always_comb begin
    wr0_ok = We0_i && !Busy_o && !((R0_IS_ZERO != 0) && (Wsel0_i == '0));
    wr1_ok = We1_i && !Busy_o && !((R0_IS_ZERO != 0) && (Wsel1_i == '0));
  end

  // Array update without reset; port 1 is written last so it wins on an address collision.
  always_ff @(posedge Clk_i) begin
    if (clr_we) begin
      regs[clr_idx] <= '0;
    end else begin
      if (wr0_ok) regs[Wsel0_i] <= Wdata0_i;
      if (wr1_ok) regs[Wsel1_i] <= Wdata1_i;
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    logic [AW-1:0] sel;
    assign sel = Rsel_i[k*AW +: AW];

    // Read mux: busy masks everything, then R0, then bypass (port 1 first), then the array.
    always_comb begin
      Rdata_o[k*REG_WIDTH +: REG_WIDTH] = regs[sel];
      if (Busy_o) begin
        Rdata_o[k*REG_WIDTH +: REG_WIDTH] = '0;
      end else if ((R0_IS_ZERO != 0) && (sel == '0)) begin
        Rdata_o[k*REG_WIDTH +: REG_WIDTH] = '0;
      end else if ((BYPASS != 0) && We1_i && (Wsel1_i == sel)) begin
        Rdata_o[k*REG_WIDTH +: REG_WIDTH] = Wdata1_i;
      end else if ((BYPASS != 0) && We0_i && (Wsel0_i == sel)) begin
        Rdata_o[k*REG_WIDTH +: REG_WIDTH] = Wdata0_i;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp with default parameters (32x32, 2 read ports).
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
// Each scenario task does its own comparisons against hand-computed values.
module tb_regfile_mp;

  logic        Clk_i;
  logic        Rst_ni;
  logic        Clr_i;
  logic        Busy_o;
  logic [9:0]  Rsel_i;
  logic [63:0] Rdata_o;
  logic        We0_i;
  logic [4:0]  Wsel0_i;
  logic [31:0] Wdata0_i;
  logic        We1_i;
  logic [4:0]  Wsel1_i;
  logic [31:0] Wdata1_i;

  int n_checks;
  int n_errors;

  regfile_mp dut (
    .Clk_i    (Clk_i),
    .Rst_ni   (Rst_ni),
    .Clr_i    (Clr_i),
    .Busy_o   (Busy_o),
    .Rsel_i   (Rsel_i),
    .Rdata_o  (Rdata_o),
    .We0_i    (We0_i),
    .Wsel0_i  (Wsel0_i),
    .Wdata0_i (Wdata0_i),
    .We1_i    (We1_i),
    .Wsel1_i  (Wsel1_i),
    .Wdata1_i (Wdata1_i)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    Clr_i    = 1'b0;
    We0_i    = 1'b0;
    Wsel0_i  = '0;
    Wdata0_i = '0;
    We1_i    = 1'b0;
    Wsel1_i  = '0;
    Wdata1_i = '0;
  endtask

  task automatic test_reset();
    int n;
    Rst_ni = 1'b0;
    idle_inputs();
    Rsel_i = {5'd3, 5'd1};
    repeat (3) tick();
    #1;
    n_checks++;
    if (Busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_busy: got %b want 1", Busy_o);
    end
    n_checks++;
    if (Rdata_o !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h want 0", Rdata_o);
    end
    Rst_ni = 1'b1;
    n = 0;
    while (Busy_o && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 32) begin
      n_errors++;
      $display("FAIL reset_busy_cycles: got %0d want 32", n);
    end
    for (int i = 0; i < 32; i++) begin
      Rsel_i = {5'(31 - i), 5'(i)};
      #1;
      n_checks++;
      if (Rdata_o !== 64'h0) begin
        n_errors++;
        $display("FAIL reset_all_zero[%0d]: got %h want 0", i, Rdata_o);
      end
    end
  endtask

  task automatic test_write_read();
    We0_i = 1'b1; Wsel0_i = 5'd5; Wdata0_i = 32'hDEADBEEF;
    Rsel_i = {5'd5, 5'd5};
    #1;
    n_checks++;
    if (Rdata_o !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL wr_bypass_x5: got %h want deadbeefdeadbeef", Rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (Rdata_o !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL wr_read_x5: got %h want deadbeefdeadbeef", Rdata_o);
    end
  endtask

  task automatic test_same_addr();
    We0_i = 1'b1; Wsel0_i = 5'd7; Wdata0_i = 32'h11;
    We1_i = 1'b1; Wsel1_i = 5'd7; Wdata1_i = 32'h22;
    Rsel_i = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (Rdata_o !== {32'h22, 32'h22}) begin
      n_errors++;
      $display("FAIL same_addr_bypass: got %h want 0000002200000022", Rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (Rdata_o !== {32'h22, 32'h22}) begin
      n_errors++;
      $display("FAIL same_addr_stored: got %h want 0000002200000022", Rdata_o);
    end
  endtask

  task automatic test_back_to_back();
    We0_i = 1'b1; Wsel0_i = 5'd10; Wdata0_i = 32'hA0A0_0010;
    We1_i = 1'b1; Wsel1_i = 5'd9;  Wdata1_i = 32'hB1B1_0009;
    Rsel_i = {5'd9, 5'd10};
    #1;
    n_checks++;
    if (Rdata_o !== {32'hB1B1_0009, 32'hA0A0_0010}) begin
      n_errors++;
      $display("FAIL b2b_bypass: got %h want b1b10009a0a00010", Rdata_o);
    end
    tick();
    We0_i = 1'b1; Wsel0_i = 5'd9; Wdata0_i = 32'h0000_1234;
    We1_i = 1'b0;
    Rsel_i = {5'd10, 5'd9};
    #1;
    n_checks++;
    if (Rdata_o !== {32'hA0A0_0010, 32'h0000_1234}) begin
      n_errors++;
      $display("FAIL b2b_second: got %h want a0a0001000001234", Rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (Rdata_o !== {32'hA0A0_0010, 32'h0000_1234}) begin
      n_errors++;
      $display("FAIL b2b_stored: got %h want a0a0001000001234", Rdata_o);
    end
  endtask

  task automatic test_r0();
    We0_i = 1'b1; Wsel0_i = 5'd0; Wdata0_i = 32'hFFFF_FFFF;
    We1_i = 1'b1; Wsel1_i = 5'd0; Wdata1_i = 32'hFFFF_FFFF;
    Rsel_i = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (Rdata_o !== 64'h0) begin
      n_errors++;
      $display("FAIL r0_same_cycle: got %h want 0", Rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (Rdata_o !== 64'h0) begin
      n_errors++;
      $display("FAIL r0_next_cycle: got %h want 0", Rdata_o);
    end
  endtask

  task automatic test_clear_drop();
    int n;
    for (int i = 1; i < 32; i++) begin
      We0_i = 1'b1; Wsel0_i = 5'(i); Wdata0_i = 32'h1000 * i + i;
      tick();
    end
    idle_inputs();
    Rsel_i = {5'd20, 5'd3};
    #1;
    n_checks++;
    if (Rdata_o !== {32'h0001_4014, 32'h0000_3003}) begin
      n_errors++;
      $display("FAIL fill_readback: got %h want 0001401400003003", Rdata_o);
    end
    Clr_i = 1'b1;
    tick();
    Clr_i = 1'b0;
    n = 0;
    while (Busy_o && n < 100) begin
      if (n == 10) begin
        We0_i = 1'b1; Wsel0_i = 5'd3; Wdata0_i = 32'h55;
        Rsel_i = {5'd3, 5'd3};
        #1;
        n_checks++;
        if (Rdata_o !== 64'h0) begin
          n_errors++;
          $display("FAIL clear_read_masked: got %h want 0", Rdata_o);
        end
      end
      tick();
      We0_i = 1'b0;
      n++;
    end
    n_checks++;
    if (n !== 32) begin
      n_errors++;
      $display("FAIL clear_busy_cycles: got %0d want 32", n);
    end
    Rsel_i = {5'd20, 5'd3};
    #1;
    n_checks++;
    if (Rdata_o !== 64'h0) begin
      n_errors++;
      $display("FAIL clear_x3_dropped: got %h want 0", Rdata_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    Clr_i = 1'b1;
    tick();
    Clr_i = 1'b0;
    repeat (10) tick();
    #2;
    Rst_ni = 1'b0;
    #1;
    n_checks++;
    if (Busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL midclr_reset_busy: got %b want 1", Busy_o);
    end
    tick();
    Rst_ni = 1'b1;
    n = 0;
    while (Busy_o && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 32) begin
      n_errors++;
      $display("FAIL midclr_busy_cycles: got %0d want 32", n);
    end
    We1_i = 1'b1; Wsel1_i = 5'd12; Wdata1_i = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    Rsel_i = {5'd12, 5'd5};
    #1;
    n_checks++;
    if (Rdata_o !== {32'hCAFE_F00D, 32'h0}) begin
      n_errors++;
      $display("FAIL midclr_post_write: got %h want cafef00d00000000", Rdata_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Rst_ni   = 1'b0;
    Rsel_i   = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_same_addr();
    test_back_to_back();
    test_r0();
    test_clear_drop();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
